// File: rtl/mult_pkg.sv
// Shared widths and pipeline stage records for the shared-multiplier arbiter.
package mult_pkg;
    localparam int OPERAND_BITS = 8;
    localparam int PRODUCT_BITS = 16;
    localparam int MAX_ID_BITS  = 3;

    typedef struct packed {
        logic [OPERAND_BITS-1:0] a;
        logic [OPERAND_BITS-1:0] b;
        logic                    sgnd;
        logic [MAX_ID_BITS-1:0]  id;
    } s1_t;

    typedef struct packed {
        logic [PRODUCT_BITS-1:0] p;
        logic [MAX_ID_BITS-1:0]  id;
    } s2_t;
endpackage

// File: rtl/multiplier.sv
// Combinational 8x8 multiplier, signed or unsigned per operation, 16-bit truncated result.
module multiplier
    import mult_pkg::*;
(
    input  logic [OPERAND_BITS-1:0] a_i,
    input  logic [OPERAND_BITS-1:0] b_i,
    input  logic                    sgnd_i,
    output logic [PRODUCT_BITS-1:0] p_o
);
    logic signed [PRODUCT_BITS-1:0] a_ext;
    logic signed [PRODUCT_BITS-1:0] b_ext;

    // Low 16 bits of a 16x16 product are sign-agnostic once operands are extended.
    assign a_ext = {{(PRODUCT_BITS-OPERAND_BITS){sgnd_i & a_i[OPERAND_BITS-1]}}, a_i};
    assign b_ext = {{(PRODUCT_BITS-OPERAND_BITS){sgnd_i & b_i[OPERAND_BITS-1]}}, b_i};
    assign p_o   = a_ext * b_ext;
endmodule

// File: rtl/rr_arbiter.sv
// Request arbiter: round-robin when MULT_ARB_ROUND_ROBIN_EN is defined, else fixed lowest-index priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_BITS-1:0] gnt_id_o
);
    logic found;
    int   win;

`ifdef MULT_ARB_ROUND_ROBIN_EN
    logic [ID_BITS-1:0] ptr_q, ptr_d;
    int                 best_d;
    int                 dist;

    // Winner is the requester with the smallest rotational distance from the pointer.
    always_comb begin
        found  = 1'b0;
        win    = 0;
        best_d = NUM_REQ;
        dist   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist = (i + NUM_REQ - int'(ptr_q)) % NUM_REQ;
            if (req_i[i] && dist < best_d) begin
                best_d = dist;
                win    = i;
                found  = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = ID_BITS'((win + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, advance_i};

    always_comb begin
        found = 1'b0;
        win   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win   = i;
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i] = found && (win == i);
        end
        gnt_id_o = ID_BITS'(win);
    end
endmodule

// File: rtl/mult_arbiter.sv
// Several requesters share one multiplier through a two-stage pipeline (operands, then product).
// Arbitration mode selected by MULT_ARB_ROUND_ROBIN_EN (defined: round-robin, else fixed priority).
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [OPERAND_BITS*NUM_REQ-1:0] req_a,
    input  logic [OPERAND_BITS*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]              req_sgnd,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_BITS-1:0]              rsp_id,
    output logic [PRODUCT_BITS-1:0]         rsp_p,
    output logic                            busy
);
    s1_t                     s1_q, s1_d;
    logic                    s1_vld_q;
    s2_t                     s2_q;
    logic                    s2_vld_q;
    logic [NUM_REQ-1:0]      gnt;
    logic [ID_BITS-1:0]      gnt_id;
    logic [PRODUCT_BITS-1:0] prod;
    logic                    s1_adv, s2_adv, permit, transfer;

    assign s2_adv    = s2_vld_q && rsp_ready;
    assign s1_adv    = s1_vld_q && (!s2_vld_q || s2_adv);
    assign permit    = (!s1_vld_q || s1_adv) && !rst;
    assign req_ready = permit ? gnt : '0;
    assign transfer  = |req_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .advance_i (transfer),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id)
    );

    always_comb begin
        s1_d    = '0;
        s1_d.id = MAX_ID_BITS'(gnt_id);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                s1_d.a    = req_a[OPERAND_BITS*i +: OPERAND_BITS];
                s1_d.b    = req_b[OPERAND_BITS*i +: OPERAND_BITS];
                s1_d.sgnd = req_sgnd[i];
            end
        end
    end

    // ---- stage 1: granted operands ----
    always_ff @(posedge clk) begin
        if (transfer) begin
            s1_q <= s1_d;
        end
    end

    multiplier u_mul (
        .a_i    (s1_q.a),
        .b_i    (s1_q.b),
        .sgnd_i (s1_q.sgnd),
        .p_o    (prod)
    );

    // ---- stage 2: product awaiting the consumer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else begin
            if (transfer) begin
                s1_vld_q <= 1'b1;
            end else if (s1_adv) begin
                s1_vld_q <= 1'b0;
            end
            if (s1_adv) begin
                s2_vld_q <= 1'b1;
                s2_q.p   <= prod;
                s2_q.id  <= s1_q.id;
            end else if (s2_adv) begin
                s2_vld_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = s2_vld_q;
    assign rsp_p     = s2_q.p;
    assign rsp_id    = ID_BITS'(s2_q.id);
    assign busy      = s1_vld_q || s2_vld_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus random traffic against a queue-based reference.
module tb_mult_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_ready, req_sgnd;
    logic [8*N-1:0] req_a, req_b;
    logic          rsp_valid, rsp_ready, busy;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_p;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_p[$];
    int          exp_id[$];
    int          mptr     = 0;
    bit          just_acc = 1'b0;
    int          last_win = -1;
    int          dut_acc  = 0;

`ifdef MULT_ARB_ROUND_ROBIN_EN
    int exp_w[5] = '{0, 1, 2, 3, 0};
`else
    int exp_w[5] = '{0, 0, 0, 0, 0};
`endif

    mult_arbiter #(.NUM_REQ(N), .ID_BITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sgnd  (req_sgnd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(logic [7:0] a, logic [7:0] b, logic s);
        int r;
        if (s) r = int'($signed(a)) * int'($signed(b));
        else   r = int'(a) * int'(b);
        return r[15:0];
    endfunction

    task automatic set_op(int i, logic [7:0] a, logic [7:0] b, logic s);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_sgnd[i]     = s;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            set_op(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    // One clock: check at the falling edge, then update the model at the rising edge.
    task automatic cycle();
        int           win;
        int           idx;
        int           n;
        bit           permit, exp_rv, accept, drain;
        logic [N-1:0] exp_rdy;
        logic [15:0]  newp;
        @(negedge clk);
        n      = exp_id.size();
        permit = (n < 2) || rsp_ready;
        win    = -1;
        for (int off = 0; off < N; off++) begin
            idx = (mptr + off) % N;
            if (win < 0 && req_valid[idx]) win = idx;
        end
        exp_rdy = (permit && win >= 0) ? N'(1 << win) : '0;
        exp_rv  = (n == 2) || (n == 1 && !just_acc);
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("busy", busy, n > 0);
        if (exp_rv) begin
            chk("rsp_p", rsp_p, exp_p[0]);
            chk("rsp_id", rsp_id, exp_id[0]);
        end
        if ((req_valid & req_ready) != '0) dut_acc++;
        accept = (exp_rdy != '0);
        drain  = exp_rv && rsp_ready;
        newp   = 16'h0;
        if (accept) newp = ref_mul(req_a[8*win +: 8], req_b[8*win +: 8], req_sgnd[win]);
        @(posedge clk);
        if (drain) begin
            void'(exp_p.pop_front());
            void'(exp_id.pop_front());
        end
        if (accept) begin
            exp_p.push_back(newp);
            exp_id.push_back(win);
`ifdef MULT_ARB_ROUND_ROBIN_EN
            mptr = (win + 1) % N;
`endif
        end
        just_acc = accept;
        last_win = accept ? win : -1;
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_rsp_id", rsp_id, 0);
        exp_p.delete();
        exp_id.delete();
        mptr      = 0;
        just_acc  = 1'b0;
        last_win  = -1;
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic single_op(logic [7:0] a, logic [7:0] b, logic s, logic [15:0] p);
        rsp_ready = 1'b1;
        set_op(0, a, b, s);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();
        chk("lat_valid", rsp_valid, 1);
        chk("lat_p", rsp_p, p);
        chk("lat_id", rsp_id, 0);
        cycle();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sgnd  = '0;
        rsp_ready = 1'b1;
        do_reset();

        single_op(8'h0F, 8'h11, 1'b0, 16'h00FF);
        single_op(8'hFF, 8'h02, 1'b1, 16'hFFFE);
        single_op(8'hFF, 8'h02, 1'b0, 16'h01FE);
        single_op(8'h80, 8'h80, 1'b1, 16'h4000);
        single_op(8'hFF, 8'hFF, 1'b0, 16'hFE01);

        do_reset();
        rand_ops();
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("grant_order", last_win, exp_w[k]);
        end
        req_valid = '0;
        repeat (3) cycle();

        do_reset();
        rand_ops();
        req_valid = '1;
        rsp_ready = 1'b0;
        dut_acc   = 0;
        repeat (5) cycle();
        chk("stall_accepts", dut_acc, 2);
        chk("stall_ready", req_ready, 0);
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (4) cycle();
        chk("drain_busy", busy, 0);

        do_reset();
        rand_ops();
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (3) cycle();
        chk("full_busy", busy, 1);
        do_reset();
        rsp_ready = 1'b1;
        repeat (4) cycle();

        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int g = 0; g < 10 && exp_id.size() > 0; g++) begin
            cycle();
        end
        chk("final_drain", exp_id.size(), 0);
        chk("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
